// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
// Holds the depth / count-width derivations, the threshold helpers used by
// the almost-full / almost-empty flags, and a clog2 helper that the async
// FIFO variants also use.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  // Ceiling log2; returns 0 for inputs 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One extra bit so occupancy 0..DEPTH is representable.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Occupancy at or above which almost_full asserts.
  function automatic int unsigned afull_thresh(input int unsigned addr_width,
                                               input int unsigned margin);
    return (margin >= fifo_depth(addr_width)) ? 0 : fifo_depth(addr_width) - margin;
  endfunction

  localparam int unsigned DEF_DEPTH       = fifo_depth(DEF_ADDR_WIDTH);
  localparam int unsigned DEF_COUNT_WIDTH = count_width(DEF_ADDR_WIDTH);

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage for sync_fifo_param.
// Synchronous write; read is either registered (REG_READ=1, output register
// updated on i_re and cleared by reset) or combinational (REG_READ=0).
// Ports:
//   clk, rst_n      clock and synchronous active-low reset (read register only)
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr    read port (i_re only used in registered mode)
//   o_rdata         read data
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit          REG_READ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  // Contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  if (REG_READ) begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rdata <= '0;
      end else if (i_re) begin
        r_rdata <= r_mem[i_raddr];
      end
    end

    assign o_rdata = r_rdata;
  end else begin : g_comb_read
    logic w_unused;
    assign w_unused = &{1'b0, rst_n, i_re};
    assign o_rdata  = r_mem[i_raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through,
// programmable almost-full/almost-empty, fill count, synchronous flush and
// sticky overflow/underflow flags.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             clear contents (error flags kept)
//   clr_err           clear sticky error flags
//   winc, wdata       write request / data
//   rinc              read (pop) request
//   rdata, rvalid     read data / valid
//   wfull, already_wfull, rempty, already_rempty, almost_full, almost_empty
//   count             occupancy 0..DEPTH
//   overflow, underflow  sticky error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter bit          FWFT          = 1'b0,
  parameter int unsigned AFULL_MARGIN  = 2,
  parameter int unsigned AEMPTY_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wfull,
  output logic                  already_wfull,
  output logic                  rempty,
  output logic                  already_rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CW    = count_width(ADDR_WIDTH);

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_CNT    = CW'(1);
  localparam logic [CW-1:0] AFULL_TH   = CW'(afull_thresh(ADDR_WIDTH, AFULL_MARGIN));
  localparam logic [CW-1:0] AEMPTY_TH  = CW'((AEMPTY_MARGIN > DEPTH) ? DEPTH : AEMPTY_MARGIN);

  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic                r_overflow;
  logic                r_underflow;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wa;
  logic          w_ra;
  logic          w_ovf_set;
  logic          w_unf_set;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                   (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_count = r_wptr - r_rptr;

  // Flush swallows same-cycle requests, including their error side effects.
  assign w_wa      = winc & ~w_full  & ~flush;
  assign w_ra      = rinc & ~w_empty & ~flush;
  assign w_ovf_set = winc &  w_full  & ~flush;
  assign w_unf_set = rinc &  w_empty & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wa) r_wptr <= r_wptr + 1'b1;
      if (w_ra) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Set takes priority over clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;
      if (w_unf_set)    r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   (!FWFT)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wa),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (wdata),
    .i_re    (w_ra),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (rdata)
  );

  if (FWFT) begin : g_fwft
    assign rvalid = ~w_empty;
  end else begin : g_std
    logic r_rvalid;

    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_ra;
      end
    end

    assign rvalid = r_rvalid;
  end

  assign wfull          = w_full;
  assign rempty         = w_empty;
  assign already_wfull  = (w_count == LAST_CNT);
  assign already_rempty = (w_count == ONE_CNT);
  assign almost_full    = (w_count >= AFULL_TH);
  assign almost_empty   = (w_count <= AEMPTY_TH);
  assign count          = w_count;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;

  logic w_unused;
  assign w_unused = &{1'b0, FULL_CNT};

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        clr_err;

  logic        winc;
  logic [31:0] wdata;
  logic        rinc;
  logic [31:0] rdata;
  logic        rvalid, wfull, already_wfull, rempty, already_rempty;
  logic        almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;

  logic        f_winc;
  logic [7:0]  f_wdata;
  logic        f_rinc;
  logic [7:0]  f_rdata;
  logic        f_rvalid, f_wfull, f_already_wfull, f_rempty, f_already_rempty;
  logic        f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [2:0]  f_count;

  int unsigned n_cmp;
  int unsigned n_err;

  sync_fifo_param #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (4),
    .FWFT          (1'b0),
    .AFULL_MARGIN  (2),
    .AEMPTY_MARGIN (2)
  ) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush), .clr_err (clr_err),
    .winc (winc), .wdata (wdata), .rinc (rinc),
    .rdata (rdata), .rvalid (rvalid), .wfull (wfull),
    .already_wfull (already_wfull), .rempty (rempty),
    .already_rempty (already_rempty), .almost_full (almost_full),
    .almost_empty (almost_empty), .count (count),
    .overflow (overflow), .underflow (underflow)
  );

  sync_fifo_param #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (2),
    .FWFT          (1'b1),
    .AFULL_MARGIN  (1),
    .AEMPTY_MARGIN (1)
  ) dut_fwft (
    .clk (clk), .rst_n (rst_n), .flush (flush), .clr_err (clr_err),
    .winc (f_winc), .wdata (f_wdata), .rinc (f_rinc),
    .rdata (f_rdata), .rvalid (f_rvalid), .wfull (f_wfull),
    .already_wfull (f_already_wfull), .rempty (f_rempty),
    .already_rempty (f_already_rempty), .almost_full (f_almost_full),
    .almost_empty (f_almost_empty), .count (f_count),
    .overflow (f_overflow), .underflow (f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
    winc = 1'b0; wdata = '0; rinc = 1'b0;
    f_winc = 1'b0; f_wdata = '0; f_rinc = 1'b0;

    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset / idle state
    check("rst_rempty",   rempty, 1);
    check("rst_aempty",   almost_empty, 1);
    check("rst_count",    count, 0);
    check("rst_rdata",    rdata, 0);
    check("rst_rvalid",   rvalid, 0);
    check("rst_wfull",    wfull, 0);
    check("rst_ovf",      overflow, 0);
    check("rst_unf",      underflow, 0);
    check("f_rst_rempty", f_rempty, 1);
    check("f_rst_rvalid", f_rvalid, 0);

    // FWFT: head visible the cycle after its write, without rinc
    f_winc = 1'b1; f_wdata = 8'hA5;
    tick();
    f_winc = 1'b0;
    check("f_rdata",  f_rdata, 8'hA5);
    check("f_rvalid", f_rvalid, 1);
    check("f_count",  f_count, 1);
    tick();
    check("f_rdata_hold", f_rdata, 8'hA5);
    f_rinc = 1'b1;
    tick();
    f_rinc = 1'b0;
    check("f_pop_rempty", f_rempty, 1);
    check("f_pop_rvalid", f_rvalid, 0);

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 32'(i);
      tick();
      check("fill_count",  count, 64'(i + 1));
      check("fill_afull",  almost_full, (i + 1) >= 14);
      check("fill_awfull", already_wfull, (i + 1) == 15);
      check("fill_wfull",  wfull, (i + 1) == 16);
      check("fill_aempty", almost_empty, (i + 1) <= 2);
    end
    winc = 1'b0;

    // Drain: data appears one cycle after accepted rinc
    for (int i = 0; i < 16; i++) begin
      rinc = 1'b1;
      tick();
      check("drain_rdata",  rdata, 64'(i));
      check("drain_rvalid", rvalid, 1);
      check("drain_count",  count, 64'(15 - i));
      check("drain_rempty", rempty, (15 - i) == 0);
      check("drain_arempty", already_rempty, (15 - i) == 1);
      check("drain_aempty", almost_empty, (15 - i) <= 2);
    end
    rinc = 1'b0;
    tick();
    check("idle_rvalid", rvalid, 0);
    check("idle_rdata_hold", rdata, 15);

    // Wrap-around: 40 single write/read pairs cross the pointer wrap
    for (int i = 0; i < 40; i++) begin
      winc = 1'b1; wdata = 32'(100 + i);
      tick();
      winc = 1'b0;
      check("wrap_count1", count, 1);
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      check("wrap_rdata",  rdata, 64'(100 + i));
      check("wrap_count0", count, 0);
    end

    // Full with simultaneous winc & rinc
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 32'(200 + i);
      tick();
    end
    check("full_wfull", wfull, 1);
    rinc = 1'b1; wdata = 32'hDEAD;
    tick();
    winc = 1'b0; rinc = 1'b0;
    check("full_both_count", count, 15);
    check("full_both_ovf",   overflow, 1);
    check("full_both_unf",   underflow, 0);
    check("full_both_rdata", rdata, 200);
    check("full_both_rvalid", rvalid, 1);
    for (int i = 0; i < 15; i++) begin
      rinc = 1'b1;
      tick();
      check("full_drain_rdata", rdata, 64'(201 + i));
    end
    rinc = 1'b0;
    check("full_drain_count", count, 0);

    // Empty with simultaneous winc & rinc
    winc = 1'b1; rinc = 1'b1; wdata = 32'h77;
    tick();
    winc = 1'b0; rinc = 1'b0;
    check("empty_both_count",  count, 1);
    check("empty_both_unf",    underflow, 1);
    check("empty_both_rvalid", rvalid, 0);
    check("empty_both_ovf",    overflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_unf", underflow, 0);
    rinc = 1'b1;
    tick();
    check("empty_word_rdata", rdata, 32'h77);
    // rinc now hits an empty FIFO while clr_err is high: set must win
    clr_err = 1'b1;
    tick();
    rinc = 1'b0;
    check("set_wins_unf", underflow, 1);
    tick();
    clr_err = 1'b0;
    check("clr_after_unf", underflow, 0);

    // Flush: set underflow first so flag preservation is observable
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("pre_flush_unf", underflow, 1);
    for (int i = 0; i < 7; i++) begin
      winc = 1'b1; wdata = 32'(300 + i);
      tick();
    end
    check("pre_flush_count", count, 7);
    flush = 1'b1; wdata = 32'hEE;
    tick();
    flush = 1'b0; winc = 1'b0;
    check("flush_count",  count, 0);
    check("flush_rempty", rempty, 1);
    check("flush_unf",    underflow, 1);
    check("flush_ovf",    overflow, 0);
    check("flush_rvalid", rvalid, 0);
    winc = 1'b1; wdata = 32'h55;
    tick();
    winc = 1'b0; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("post_flush_rdata", rdata, 32'h55);

    // Reset mid-burst
    for (int i = 0; i < 6; i++) begin
      winc = 1'b1; wdata = 32'(400 + i);
      rinc = (i >= 4);
      tick();
    end
    check("burst_count", count, 4);
    check("burst_rdata", rdata, 401);
    rst_n = 1'b0;
    tick();
    check("mid_rst_count",  count, 0);
    check("mid_rst_rempty", rempty, 1);
    check("mid_rst_aempty", almost_empty, 1);
    check("mid_rst_wfull",  wfull, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_rdata",  rdata, 0);
    check("mid_rst_unf",    underflow, 0);
    check("mid_rst_ovf",    overflow, 0);
    rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
    tick();
    winc = 1'b1; wdata = 32'h66;
    tick();
    winc = 1'b0; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("post_rst_rdata", rdata, 32'h66);
    check("post_rst_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
